// File: rtl/ddr_line_prefetch.sv
// Line prefetcher: pulls display lines from a single DDR read channel into a
// ring of BRAM banks and serves registered pixel reads to the video pipeline.
//
// state | meaning
// IDLE  | no read outstanding; fetch starts when a bank is free and the frame is armed
// ISSUE | one-cycle mem_req for the current pixel word
// WAIT  | read outstanding; returning word is written to bank fill_bank
// DRAIN | read outstanding from a cancelled frame; returning word is dropped
module ddr_line_prefetch #(
  parameter int LINE_PIXELS = 256,
  parameter int NUM_LINES   = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 28,
  parameter int FRAME_LINES = 224,
  localparam int PIX_W      = $clog2(LINE_PIXELS)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       stride,
  input  logic              frame_start,
  input  logic              line_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [PIX_W-1:0]  rd_pix,
  output logic [DATA_W-1:0] rd_data,
  output logic              line_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int BANK_W  = $clog2(NUM_LINES);
  localparam int FILL_W  = $clog2(NUM_LINES + 1);
  localparam int LIDX_W  = $clog2(FRAME_LINES + 1);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int DEPTH   = NUM_LINES * LINE_PIXELS;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d, pix_inc;
  logic [BANK_W-1:0]   fill_bank_q, fill_bank_d;
  logic [BANK_W-1:0]   disp_bank_q, disp_bank_d;
  logic [FILL_W-1:0]   filled_q, filled_d;
  logic [LIDX_W-1:0]   line_idx_q, line_idx_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic [15:0]         stride_q, stride_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                armed_q, armed_d;
  logic                underrun_q, underrun_d;
  logic                line_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                can_fetch;
  logic                line_complete;
  logic                consume;
  logic                wr_en;

  logic [DATA_W-1:0]   bank_mem [DEPTH];

  // Fetching only starts once a frame_start has armed the frame, so a reset
  // leaves the channel quiet until the next vsync.
  assign can_fetch = armed_q && enable &&
                     (filled_q < FILL_W'(NUM_LINES)) &&
                     (line_idx_q < LIDX_W'(FRAME_LINES));
  assign pix_inc   = pix_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    fill_bank_d   = fill_bank_q;
    disp_bank_d   = disp_bank_q;
    filled_d      = filled_q;
    line_idx_d    = line_idx_q;
    line_addr_d   = line_addr_q;
    stride_d      = stride_q;
    mem_addr_d    = mem_addr_q;
    armed_d       = armed_q;
    underrun_d    = underrun_q;
    line_complete = 1'b0;
    consume       = 1'b0;
    wr_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_fetch) begin
          state_d    = ISSUE;
          mem_addr_d = line_addr_q + (ADDR_W'(pix_q) << BYTE_SH);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          wr_en = 1'b1;
          if (pix_q == PIX_LAST) begin
            line_complete = 1'b1;
            pix_d         = '0;
            fill_bank_d   = fill_bank_q + 1'b1;
            line_idx_d    = line_idx_q + 1'b1;
            line_addr_d   = line_addr_q + ADDR_W'(stride_q);
            state_d       = IDLE;
          end else begin
            pix_d      = pix_inc;
            mem_addr_d = line_addr_q + (ADDR_W'(pix_inc) << BYTE_SH);
            state_d    = ISSUE;
          end
        end
      end
      DRAIN: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (line_done) begin
      if (filled_q != '0) begin
        consume     = 1'b1;
        disp_bank_d = disp_bank_q + 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    case ({line_complete, consume})
      2'b10:   filled_d = filled_q + 1'b1;
      2'b01:   filled_d = filled_q - 1'b1;
      default: filled_d = filled_q;
    endcase

    // A new frame wins over everything else this cycle, including line_done
    // and any returning data; a read still in flight is drained, not written.
    if (frame_start) begin
      line_addr_d = base_addr;
      stride_d    = stride;
      line_idx_d  = '0;
      filled_d    = '0;
      fill_bank_d = '0;
      disp_bank_d = '0;
      pix_d       = '0;
      underrun_d  = 1'b0;
      armed_d     = 1'b1;
      wr_en       = 1'b0;
      if (state_q == ISSUE ||
          ((state_q == WAIT || state_q == DRAIN) && !mem_ready))
        state_d = DRAIN;
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      fill_bank_q  <= '0;
      disp_bank_q  <= '0;
      filled_q     <= '0;
      line_idx_q   <= '0;
      line_addr_q  <= '0;
      stride_q     <= '0;
      mem_addr_q   <= '0;
      armed_q      <= 1'b0;
      underrun_q   <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      fill_bank_q  <= fill_bank_d;
      disp_bank_q  <= disp_bank_d;
      filled_q     <= filled_d;
      line_idx_q   <= line_idx_d;
      line_addr_q  <= line_addr_d;
      stride_q     <= stride_d;
      mem_addr_q   <= mem_addr_d;
      armed_q      <= armed_d;
      underrun_q   <= underrun_d;
      line_valid_q <= (filled_d != '0);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en && !reset) bank_mem[{fill_bank_q, pix_q}] <= mem_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= bank_mem[{disp_bank_q, rd_pix}];
  end

  assign mem_req    = (state_q == ISSUE);
  assign mem_addr   = mem_addr_q;
  assign rd_data    = rd_data_q;
  assign line_valid = line_valid_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_line_prefetch.sv
// Bench for ddr_line_prefetch: a 3-cycle-latency memory responder scoreboards
// every request address; vector table and directed sequences check the rest.
module tb_ddr_line_prefetch;
  localparam int LP = 256, NL = 2, DW = 32, AW = 28, FL = 3, PW = 8, RDLY = 3;

  logic          clk_sys = 1'b0;
  logic          reset, enable, frame_start, line_done;
  logic [AW-1:0] base_addr, mem_addr;
  logic [15:0]   stride;
  logic          mem_req, mem_ready;
  logic [DW-1:0] mem_dout, rd_data;
  logic [PW-1:0] rd_pix;
  logic          line_valid, underrun, busy;

  int checks = 0, errors = 0;
  int req_cnt = 0, rdy_cnt = 0, pend = 0;
  bit fired, pend_rst;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] exp_q [$];

  typedef struct {
    logic [PW-1:0] pix;
    logic [DW-1:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab [6];
  int pix_list [6] = '{0, 1, 37, 128, 254, 255};

  always #5 clk_sys = ~clk_sys;

  ddr_line_prefetch #(
    .LINE_PIXELS(LP), .NUM_LINES(NL), .DATA_W(DW), .ADDR_W(AW), .FRAME_LINES(FL)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable),
    .base_addr(base_addr), .stride(stride), .frame_start(frame_start),
    .line_done(line_done), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_dout(mem_dout), .rd_pix(rd_pix),
    .rd_data(rd_data), .line_valid(line_valid), .underrun(underrun), .busy(busy)
  );

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {4'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_rdy(input int n, input int budget);
    int t = 0;
    while (rdy_cnt < n && t < budget) begin @(negedge clk_sys); t++; end
    check("wait_ready_bound", rdy_cnt >= n, 1);
  endtask

  task automatic wait_req(input int n, input int budget);
    int t = 0;
    while (req_cnt < n && t < budget) begin @(negedge clk_sys); t++; end
    check("wait_req_bound", req_cnt >= n, 1);
  endtask

  task automatic push_line(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b + AW'(4 * i));
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input logic [15:0] s);
    base_addr = b; stride = s; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_done();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
  endtask

  task automatic read_check(input string name, input int p, input logic [DW-1:0] exp);
    rd_pix = PW'(p);
    tick();
    check(name, rd_data, exp);
  endtask

  // Memory model: answers each request RDLY cycles later and scoreboards addresses.
  initial begin
    mem_ready = 1'b0; mem_dout = '0; pend_addr = '0; pend_rst = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      fired = 1'b0;
      mem_ready = 1'b0;
      if (reset) pend_rst = 1'b1;
      if (pend > 0) begin
        if (!pend_rst) check("addr_hold", mem_addr, pend_addr);
        pend--;
        if (pend == 0) begin
          mem_ready = 1'b1;
          mem_dout  = dfun(pend_addr);
          rdy_cnt++;
          fired = 1'b1;
        end
      end
      if (mem_req) begin
        check("req_spacing", (pend != 0) || fired, 0);
        check("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("req_addr", mem_addr, exp_q.pop_front());
        pend_addr = mem_addr;
        pend      = RDLY;
        pend_rst  = 1'b0;
        req_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      rd_tab[i].pix = PW'(pix_list[i]);
      rd_tab[i].exp = dfun(AW'(32'h1000 + 4 * pix_list[i]));
    end
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; line_done = 1'b0;
    rd_pix = '0; base_addr = '0; stride = '0;
    tick(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    enable = 1'b1;
    tick(5);
    check("no_req_before_frame", req_cnt, 0);

    // Two lines fill the ring, then fetching stops.
    push_line(28'h1000, LP);
    push_line(28'h1400, LP);
    start_frame(28'h1000, 16'd1024);
    wait_rdy(256, 3000);
    check("lv_at_last_word", line_valid, 0);
    tick();
    check("lv_after_line", line_valid, 1);
    wait_rdy(512, 3000);
    tick(20);
    check("ring_full_reqs", req_cnt, 512);
    check("ring_full_busy", busy, 0);
    check("ring_full_queue", exp_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      rd_pix = rd_tab[i].pix;
      tick();
      check("rd_tab", rd_data, rd_tab[i].exp);
    end

    // Consuming bank 0 frees it for line 2 at 0x1800.
    push_line(28'h1800, LP);
    pulse_done();
    read_check("rd_disp1", 37, dfun(28'h1494));
    check("lv_one_left", line_valid, 1);
    wait_rdy(768, 3000);
    tick(20);
    check("refill_reqs", req_cnt, 768);
    check("refill_queue", exp_q.size(), 0);

    // Drain the ring; frame is exhausted so nothing else is fetched.
    pulse_done();
    read_check("rd_refilled", 9, dfun(28'h1824));
    pulse_done();
    check("lv_empty", line_valid, 0);
    check("no_underrun_yet", underrun, 0);
    pulse_done();
    check("underrun_set", underrun, 1);
    read_check("disp_unchanged", 3, dfun(28'h140C));
    check("frame_lines_stop", req_cnt, 768);

    // Frame restart in the middle of a line while a read is outstanding.
    push_line(28'h40000, 101);
    start_frame(28'h40000, 16'h0400);
    check("underrun_cleared", underrun, 0);
    wait_req(869, 2000);
    tick();
    push_line(28'h80000, LP);
    push_line(28'h80400, LP);
    start_frame(28'h80000, 16'h0400);
    check("drain_busy", busy, 1);
    wait_rdy(869, 20);
    check("no_req_during_drain", req_cnt, 869);
    tick();
    read_check("stale_not_w100", 100, dfun(28'h1990));
    read_check("stale_not_w0", 0, dfun(28'h40000));
    wait_rdy(869 + 512, 3000);
    tick(20);
    check("restart_reqs", req_cnt, 1381);
    check("restart_queue", exp_q.size(), 0);
    read_check("restart_w0", 0, dfun(28'h80000));

    // Address wrap with a consumer; last line completes alongside line_done.
    push_line(28'hFFFFC00, LP);
    push_line(28'h0000400, LP);
    push_line(28'h0000C00, LP);
    start_frame(28'hFFFFC00, 16'h0800);
    wait_rdy(1381 + 256, 3000);
    tick();
    pulse_done();
    wait_rdy(1381 + 768, 6000);
    pulse_done();
    check("simul_lv", line_valid, 1);
    check("simul_underrun", underrun, 0);
    read_check("simul_disp", 1, dfun(28'h0000C04));
    tick(20);
    check("wrap_reqs", req_cnt, 2149);
    check("wrap_busy", busy, 0);
    check("wrap_queue", exp_q.size(), 0);
    pulse_done();
    check("simul_filled_one", line_valid, 0);
    read_check("wrap_disp1", 1, dfun(28'h0000404));

    // Reset while a read is outstanding; the late data must be ignored.
    push_line(28'h2000, 5);
    start_frame(28'h2000, 16'h0400);
    wait_req(2154, 500);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick(20);
    check("late_ready_seen", rdy_cnt, 2154);
    check("no_req_after_reset", req_cnt, 2154);
    check("idle_after_reset", busy, 0);
    read_check("late_not_w0", 0, dfun(28'h2000));
    read_check("late_not_w4", 4, dfun(28'h0000C10));

    push_line(28'h3000, LP);
    push_line(28'h3400, LP);
    start_frame(28'h3000, 16'h0400);
    wait_rdy(2154 + 512, 3000);
    tick(20);
    check("final_reqs", req_cnt, 2666);
    check("final_queue", exp_q.size(), 0);
    read_check("final_w255", 255, dfun(28'h33FC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
